// File: rtl/io_serdes_cfg_ctrl.sv
// io_serdes_cfg_ctrl
//   AXI-Lite configuration and link-management block for the parametrised IO
//   SERDES. It holds the lane enable mask, loopback and interrupt controls,
//   runs the link bring-up FSM with a programmable timeout, keeps a sticky
//   timeout flag with a level interrupt, and counts lane errors (saturating).
// Ports
//   axi_clk, axi_reset_n        clock, async active-low reset
//   axi_aw*/axi_w*              write address/data; ready = both valids & cc_is_enable
//   axi_ar*/axi_r*              read address/data; 1-cycle latency, one outstanding
//   cc_is_enable                qualifies all AXI valids
//   rx_received_data            async RX activity level (2-flop synchronised)
//   lane_err_pulse              per-lane single-cycle error pulses
//   rxen_ctl, txen_ctl          RX/TX enables to the datapath
//   lane_en, loopback_en        lane mask and loopback select
//   link_up, irq                link status and timeout interrupt
module io_serdes_cfg_ctrl #(
  parameter int unsigned pADDR_WIDTH = 10,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pNUM_LANE   = 12,
  parameter int unsigned pTIMEOUT_W  = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_reset_n,
  input  logic                   axi_awvalid,
  input  logic [pADDR_WIDTH+1:2] axi_awaddr,
  output logic                   axi_awready,
  input  logic                   axi_wvalid,
  input  logic [pDATA_WIDTH-1:0] axi_wdata,
  input  logic [3:0]             axi_wstrb,
  output logic                   axi_wready,
  input  logic                   axi_arvalid,
  input  logic [pADDR_WIDTH+1:2] axi_araddr,
  output logic                   axi_arready,
  output logic                   axi_rvalid,
  output logic [pDATA_WIDTH-1:0] axi_rdata,
  input  logic                   axi_rready,
  input  logic                   cc_is_enable,
  input  logic                   rx_received_data,
  input  logic [pNUM_LANE-1:0]   lane_err_pulse,
  output logic                   rxen_ctl,
  output logic                   txen_ctl,
  output logic [pNUM_LANE-1:0]   lane_en,
  output logic                   loopback_en,
  output logic                   link_up,
  output logic                   irq
);

  localparam int unsigned ERR_W = 16;
  localparam int unsigned POP_W = 6;

  localparam logic [pADDR_WIDTH+1:2] ADDR_CTRL    = pADDR_WIDTH'(0);
  localparam logic [pADDR_WIDTH+1:2] ADDR_LANE_EN = pADDR_WIDTH'(1);
  localparam logic [pADDR_WIDTH+1:2] ADDR_TIMEOUT = pADDR_WIDTH'(2);
  localparam logic [pADDR_WIDTH+1:2] ADDR_STATUS  = pADDR_WIDTH'(3);
  localparam logic [pADDR_WIDTH+1:2] ADDR_ERR_CNT = pADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LINKED = 2'd2,
    ST_TMO    = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              ctrl_q, ctrl_wr_val;
  logic [pNUM_LANE-1:0]    lane_en_q, lane_wr_val;
  logic [pTIMEOUT_W-1:0]   timeout_q, timeout_wr_val;
  logic [pTIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;
  logic [POP_W-1:0]        err_inc;
  logic [ERR_W:0]          err_sum;
  logic                    sticky_q;
  logic                    tmo_event;
  logic                    rx_meta_q, rx_sync_q;
  logic                    wr_en, rd_hs;
  logic                    wr_ctrl, wr_lane, wr_tmo, wr_status, wr_err;
  logic                    sticky_clr, err_clr;
  logic [pDATA_WIDTH-1:0]  rd_data;
  logic                    ctrl_rxen, ctrl_txen_req, ctrl_loopback, ctrl_irq_en;
  logic                    unused_wdata;

  assign ctrl_rxen     = ctrl_q[0];
  assign ctrl_txen_req = ctrl_q[1];
  assign ctrl_loopback = ctrl_q[2];
  assign ctrl_irq_en   = ctrl_q[3];

  // Only a subset of write-data bits is stored; the rest are ignored.
  assign unused_wdata = ^axi_wdata;

  // Write channel: address and data accepted together, commit on this edge.
  assign wr_en       = axi_awvalid & axi_wvalid & cc_is_enable;
  assign axi_awready = wr_en;
  assign axi_wready  = wr_en;

  assign wr_ctrl   = wr_en && (axi_awaddr == ADDR_CTRL);
  assign wr_lane   = wr_en && (axi_awaddr == ADDR_LANE_EN);
  assign wr_tmo    = wr_en && (axi_awaddr == ADDR_TIMEOUT);
  assign wr_status = wr_en && (axi_awaddr == ADDR_STATUS);
  assign wr_err    = wr_en && (axi_awaddr == ADDR_ERR_CNT);

  assign sticky_clr = wr_status && axi_wstrb[0] && axi_wdata[3];
  assign err_clr    = wr_err && (axi_wstrb != 4'b0000);

  // Byte-strobe merge of write data into each RW register.
  always_comb begin
    ctrl_wr_val    = ctrl_q;
    lane_wr_val    = lane_en_q;
    timeout_wr_val = timeout_q;
    if (axi_wstrb[0]) ctrl_wr_val = axi_wdata[3:0];
    for (int i = 0; i < int'(pNUM_LANE); i++) begin
      if (axi_wstrb[i/8]) lane_wr_val[i] = axi_wdata[i];
    end
    for (int i = 0; i < int'(pTIMEOUT_W); i++) begin
      if (axi_wstrb[i/8]) timeout_wr_val[i] = axi_wdata[i];
    end
  end

  // Configuration registers.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      ctrl_q    <= 4'b0000;
      lane_en_q <= '1;
      timeout_q <= pTIMEOUT_W'(1000);
    end else begin
      if (wr_ctrl) ctrl_q    <= ctrl_wr_val;
      if (wr_lane) lane_en_q <= lane_wr_val;
      if (wr_tmo)  timeout_q <= timeout_wr_val;
    end
  end

  // RX activity synchroniser.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      rx_meta_q <= 1'b0;
      rx_sync_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_received_data;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Link FSM state and timeout counter registers.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q   <= ST_OFF;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Link FSM next state; disabling both TX request and RX overrides all.
  always_comb begin
    state_d   = state_q;
    tmo_event = 1'b0;
    if (!ctrl_txen_req && !ctrl_rxen) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (ctrl_txen_req)              state_d = ST_WAIT;
          else if (ctrl_rxen && rx_sync_q) state_d = ST_LINKED;
        end
        ST_WAIT: begin
          if (rx_sync_q) begin
            state_d = ST_LINKED;
          end else if ((timeout_q != '0) &&
                       (tmo_cnt_q == timeout_q - pTIMEOUT_W'(1))) begin
            state_d   = ST_TMO;
            tmo_event = 1'b1;
          end
        end
        ST_TMO: begin
          if (rx_sync_q) state_d = ST_LINKED;
        end
        ST_LINKED: begin
          if (!rx_sync_q) state_d = ST_WAIT;
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Timeout counter restarts on every entry to WAIT and runs only there.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
      tmo_cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + pTIMEOUT_W'(1);
    end
  end

  // Sticky timeout flag: a new timeout beats a simultaneous W1C.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      sticky_q <= 1'b0;
    end else if (tmo_event) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  // Saturating error counter; a clear write discards that cycle's increment.
  always_comb begin
    err_inc = '0;
    for (int i = 0; i < int'(pNUM_LANE); i++) begin
      err_inc = err_inc + POP_W'(lane_err_pulse[i] & lane_en_q[i]);
    end
    err_sum = (ERR_W+1)'(err_cnt_q) + (ERR_W+1)'(err_inc);
    if (err_clr)         err_cnt_d = '0;
    else if (err_sum[ERR_W]) err_cnt_d = '1;
    else                 err_cnt_d = err_sum[ERR_W-1:0];
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) err_cnt_q <= '0;
    else              err_cnt_q <= err_cnt_d;
  end

  // Read data mux; unmapped offsets read zero.
  always_comb begin
    rd_data = '0;
    case (axi_araddr)
      ADDR_CTRL:    rd_data[3:0]            = ctrl_q;
      ADDR_LANE_EN: rd_data[pNUM_LANE-1:0]  = lane_en_q;
      ADDR_TIMEOUT: rd_data[pTIMEOUT_W-1:0] = timeout_q;
      ADDR_STATUS:  rd_data[4:0]            = {rx_sync_q, sticky_q, link_up, state_q};
      ADDR_ERR_CNT: rd_data[ERR_W-1:0]      = err_cnt_q;
      default:      rd_data                 = '0;
    endcase
  end

  // Read channel: single outstanding read, data held until accepted.
  assign axi_arready = !axi_rvalid;
  assign rd_hs       = axi_arvalid & cc_is_enable & axi_arready;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      axi_rvalid <= 1'b0;
      axi_rdata  <= '0;
    end else if (rd_hs) begin
      axi_rvalid <= 1'b1;
      axi_rdata  <= rd_data;
    end else if (axi_rvalid && axi_rready) begin
      axi_rvalid <= 1'b0;
    end
  end

  // Datapath controls decoded from register state.
  assign rxen_ctl    = ctrl_rxen;
  assign txen_ctl    = (state_q != ST_OFF);
  assign link_up     = (state_q == ST_LINKED);
  assign lane_en     = lane_en_q;
  assign loopback_en = ctrl_loopback;
  assign irq         = sticky_q & ctrl_irq_en;

endmodule

// File: tb/tb_io_serdes_cfg_ctrl.sv
// tb_io_serdes_cfg_ctrl
//   Directed bench for io_serdes_cfg_ctrl: a register read/write vector table
//   followed by hand-written sequences for link FSM, timeout, error counter,
//   cc_is_enable gating and reset during a pending read.
module tb_io_serdes_cfg_ctrl;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n;
  logic        axi_awvalid, axi_wvalid, axi_arvalid, axi_rready;
  logic [11:2] axi_awaddr, axi_araddr;
  logic        axi_awready, axi_wready, axi_arready, axi_rvalid;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic        cc_is_enable, rx_received_data;
  logic [11:0] lane_err_pulse, lane_en;
  logic        rxen_ctl, txen_ctl, loopback_en, link_up, irq;

  int tests = 0;
  int fails = 0;

  always #5 axi_clk = ~axi_clk;

  io_serdes_cfg_ctrl dut (
    .axi_clk          (axi_clk),
    .axi_reset_n      (axi_reset_n),
    .axi_awvalid      (axi_awvalid),
    .axi_awaddr       (axi_awaddr),
    .axi_awready      (axi_awready),
    .axi_wvalid       (axi_wvalid),
    .axi_wdata        (axi_wdata),
    .axi_wstrb        (axi_wstrb),
    .axi_wready       (axi_wready),
    .axi_arvalid      (axi_arvalid),
    .axi_araddr       (axi_araddr),
    .axi_arready      (axi_arready),
    .axi_rvalid       (axi_rvalid),
    .axi_rdata        (axi_rdata),
    .axi_rready       (axi_rready),
    .cc_is_enable     (cc_is_enable),
    .rx_received_data (rx_received_data),
    .lane_err_pulse   (lane_err_pulse),
    .rxen_ctl         (rxen_ctl),
    .txen_ctl         (txen_ctl),
    .lane_en          (lane_en),
    .loopback_en      (loopback_en),
    .link_up          (link_up),
    .irq              (irq)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge axi_clk);
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    #1;
    chk("awready", 32'(axi_awready & axi_wready), 32'd1);
    @(posedge axi_clk);
    #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d);
    @(negedge axi_clk);
    axi_arvalid = 1'b1; axi_araddr = a;
    @(posedge axi_clk);
    #1;
    axi_arvalid = 1'b0;
    chk("rvalid_lat", 32'(axi_rvalid), 32'd1);
    d = axi_rdata;
    axi_rready = 1'b1;
    @(posedge axi_clk);
    #1;
    axi_rready = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(a, d);
    chk(nm, d, exp);
  endtask

  // Wait up to 6 cycles for link_up to reach lvl; returns the cycle count (99 if never).
  task automatic wait_link(input logic lvl, output int k);
    k = 99;
    for (int c = 1; c <= 6; c++) begin
      @(posedge axi_clk);
      @(negedge axi_clk);
      if (link_up === lvl) begin
        k = c;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int k;

    vecs[0]  = '{1'b0, 10'h001, 32'h0,         4'h0, 32'h0000_0FFF};
    vecs[1]  = '{1'b0, 10'h002, 32'h0,         4'h0, 32'h0000_03E8};
    vecs[2]  = '{1'b0, 10'h000, 32'h0,         4'h0, 32'h0};
    vecs[3]  = '{1'b0, 10'h003, 32'h0,         4'h0, 32'h0};
    vecs[4]  = '{1'b0, 10'h004, 32'h0,         4'h0, 32'h0};
    vecs[5]  = '{1'b0, 10'h005, 32'h0,         4'h0, 32'h0};
    vecs[6]  = '{1'b1, 10'h001, 32'hFFFF_F0A5, 4'hF, 32'h0000_00A5};
    vecs[7]  = '{1'b1, 10'h001, 32'h0000_0300, 4'h2, 32'h0000_03A5};
    vecs[8]  = '{1'b1, 10'h002, 32'h0000_1234, 4'h1, 32'h0000_0334};
    vecs[9]  = '{1'b1, 10'h000, 32'h0000_0004, 4'h2, 32'h0};
    vecs[10] = '{1'b1, 10'h000, 32'h0000_0004, 4'h1, 32'h0000_0004};
    vecs[11] = '{1'b1, 10'h000, 32'h0,         4'hF, 32'h0};
    vecs[12] = '{1'b1, 10'h003, 32'h0000_001F, 4'hF, 32'h0};
    vecs[13] = '{1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF, 32'h0};
    vecs[14] = '{1'b1, 10'h004, 32'hFFFF_FFFF, 4'hF, 32'h0};

    axi_reset_n = 1'b0;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0; axi_rready = 1'b0;
    axi_awaddr = '0; axi_araddr = '0; axi_wdata = '0; axi_wstrb = '0;
    cc_is_enable = 1'b1; rx_received_data = 1'b0; lane_err_pulse = '0;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;

    // Reset state of the outputs.
    chk("rst_rxen",    32'(rxen_ctl),    32'd0);
    chk("rst_txen",    32'(txen_ctl),    32'd0);
    chk("rst_lane_en", 32'(lane_en),     32'h0000_0FFF);
    chk("rst_loop",    32'(loopback_en), 32'd0);
    chk("rst_link",    32'(link_up),     32'd0);
    chk("rst_irq",     32'(irq),         32'd0);
    chk("rst_rvalid",  32'(axi_rvalid),  32'd0);
    chk("rst_arready", 32'(axi_arready), 32'd1);

    // rvalid latency and hold while rready stays low.
    @(negedge axi_clk);
    axi_arvalid = 1'b1; axi_araddr = 10'h001;
    @(posedge axi_clk);
    #1;
    axi_arvalid = 1'b0;
    chk("hold_lat", 32'(axi_rvalid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge axi_clk);
      chk("hold_rvalid",  32'(axi_rvalid),  32'd1);
      chk("hold_rdata",   axi_rdata,        32'h0000_0FFF);
      chk("hold_arready", 32'(axi_arready), 32'd0);
    end
    axi_rready = 1'b1;
    @(posedge axi_clk);
    #1;
    axi_rready = 1'b0;
    chk("hold_release", 32'(axi_rvalid), 32'd0);

    // Register table.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      axi_read(vecs[i].addr, d);
      chk($sformatf("vec%0d", i), d, vecs[i].exp);
    end

    // Timeout: TIMEOUT=8, txen_req+irq_en; 8 WAIT cycles then TMO.
    axi_write(10'h002, 32'd8, 4'hF);
    axi_write(10'h000, 32'h0000_000A, 4'hF);
    @(posedge axi_clk);
    @(negedge axi_clk);
    chk("tmo_txen", 32'(txen_ctl), 32'd1);
    repeat (7) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("tmo_irq_early", 32'(irq), 32'd0);
    @(posedge axi_clk);
    @(negedge axi_clk);
    chk("tmo_irq_edge", 32'(irq), 32'd1);
    read_chk("tmo_status", 10'h003, 32'h0000_000B);
    axi_write(10'h000, 32'h0000_0002, 4'hF);
    chk("irq_en_off", 32'(irq), 32'd0);
    axi_write(10'h000, 32'h0000_000A, 4'hF);
    chk("irq_en_on", 32'(irq), 32'd1);
    axi_write(10'h003, 32'h0000_0008, 4'h1);
    chk("w1c_irq", 32'(irq), 32'd0);
    read_chk("w1c_status", 10'h003, 32'h0000_0003);

    // Link via WAIT, then loss of RX back to WAIT.
    axi_write(10'h000, 32'h0, 4'hF);
    @(posedge axi_clk);
    axi_write(10'h000, 32'h0000_0002, 4'hF);
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    rx_received_data = 1'b1;
    wait_link(1'b1, k);
    chk("link_latency", 32'(k), 32'd3);
    read_chk("link_status", 10'h003, 32'h0000_0016);
    @(negedge axi_clk);
    rx_received_data = 1'b0;
    wait_link(1'b0, k);
    chk("unlink_latency", 32'(k), 32'd3);
    chk("unlink_txen", 32'(txen_ctl), 32'd1);
    read_chk("unlink_status", 10'h003, 32'h0000_0001);
    axi_write(10'h000, 32'h0, 4'hF);

    // Early-remote path: rxen only with RX already active.
    @(negedge axi_clk);
    rx_received_data = 1'b1;
    repeat (3) @(posedge axi_clk);
    chk("early_off_link", 32'(link_up), 32'd0);
    axi_write(10'h000, 32'h0000_0001, 4'hF);
    @(posedge axi_clk);
    @(negedge axi_clk);
    chk("early_link", 32'(link_up),  32'd1);
    chk("early_txen", 32'(txen_ctl), 32'd1);
    chk("early_rxen", 32'(rxen_ctl), 32'd1);
    axi_write(10'h000, 32'h0, 4'hF);
    @(posedge axi_clk);
    @(negedge axi_clk);
    chk("early_off_txen", 32'(txen_ctl), 32'd0);
    chk("early_off_link2", 32'(link_up), 32'd0);
    rx_received_data = 1'b0;

    // Error counter: 4 enabled lanes for 10 cycles.
    axi_write(10'h001, 32'h0000_000F, 4'hF);
    axi_write(10'h004, 32'h0, 4'hF);
    @(negedge axi_clk);
    lane_err_pulse = 12'hFFF;
    repeat (10) @(negedge axi_clk);
    lane_err_pulse = '0;
    read_chk("err_40", 10'h004, 32'd40);

    // Saturation with all lanes enabled.
    axi_write(10'h001, 32'h0000_0FFF, 4'hF);
    @(negedge axi_clk);
    lane_err_pulse = 12'hFFF;
    repeat (5500) @(negedge axi_clk);
    lane_err_pulse = '0;
    read_chk("err_sat", 10'h004, 32'h0000_FFFF);
    axi_write(10'h004, 32'hFFFF_FFFF, 4'h0);
    read_chk("err_nostrb", 10'h004, 32'h0000_FFFF);

    // Clear coinciding with a pulse: clear wins.
    @(negedge axi_clk);
    lane_err_pulse = 12'hFFF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_awaddr = 10'h004; axi_wdata = 32'h0; axi_wstrb = 4'hF;
    @(posedge axi_clk);
    #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    lane_err_pulse = '0;
    read_chk("err_clr_wins", 10'h004, 32'h0);

    // cc_is_enable gates the write channel.
    @(negedge axi_clk);
    cc_is_enable = 1'b0;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    axi_awaddr = 10'h000; axi_wdata = 32'h0000_000F; axi_wstrb = 4'hF;
    #1;
    chk("cc_awready", 32'(axi_awready), 32'd0);
    chk("cc_wready",  32'(axi_wready),  32'd0);
    @(posedge axi_clk);
    #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    cc_is_enable = 1'b1;
    read_chk("cc_ctrl", 10'h000, 32'h0);
    chk("cc_loop", 32'(loopback_en), 32'd0);

    // Reset while a read is pending.
    axi_write(10'h001, 32'h0000_0005, 4'hF);
    axi_write(10'h002, 32'h0000_0044, 4'hF);
    @(negedge axi_clk);
    axi_arvalid = 1'b1; axi_araddr = 10'h001;
    @(posedge axi_clk);
    #1;
    axi_arvalid = 1'b0;
    chk("rst_pend_rdata", axi_rdata, 32'h0000_0005);
    #2;
    axi_reset_n = 1'b0;
    #1;
    chk("rst_pend_rvalid",  32'(axi_rvalid), 32'd0);
    chk("rst_pend_rdata0",  axi_rdata,       32'h0);
    chk("rst_pend_lane_en", 32'(lane_en),    32'h0000_0FFF);
    @(negedge axi_clk);
    axi_reset_n = 1'b1;
    read_chk("rst_pend_tmo", 10'h002, 32'h0000_03E8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_serdes_cfg_ctrl.md
Name: io_serdes_cfg_ctrl

Overview:
- AXI-Lite configuration and link-management block for the next-generation parametrised IO SERDES, in the axi_clk domain.
- Replaces the fixed two-bit enable register with:
  - per-lane enable mask, loopback and interrupt-enable controls;
  - a link bring-up state machine with programmable timeout;
  - a sticky timeout status with interrupt;
  - a saturating lane-error counter.
- Its outputs drive the SERDES TX/RX datapath. Those consumers resynchronise them to ioclk.

Parameters:
- pADDR_WIDTH, 10, DW-address width; axi_awaddr/axi_araddr are [pADDR_WIDTH+1:2].
- pDATA_WIDTH, 32, AXI-Lite data width; must be 32.
- pNUM_LANE, 12, number of serial lanes; range 1..32.
- pTIMEOUT_W, 16, width of the timeout counter and TIMEOUT register; range 1..32.

Ports:
- axi_clk  in  1  register/FSM clock.
- axi_reset_n  in  1  asynchronous active-low reset.
- axi_awvalid  in  1  write address valid.
- axi_awaddr  in  pADDR_WIDTH  DW write address.
- axi_awready  out  1  write address ready.
- axi_wvalid  in  1  write data valid.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte strobes.
- axi_wready  out  1  write data ready.
- axi_arvalid  in  1  read address valid.
- axi_araddr  in  pADDR_WIDTH  DW read address.
- axi_arready  out  1  read address ready.
- axi_rvalid  out  1  read data valid.
- axi_rdata  out  32  read data.
- axi_rready  in  1  read data ready.
- cc_is_enable  in  1  qualifies axi_awvalid/axi_wvalid/axi_arvalid.
- rx_received_data  in  1  asynchronous level from the RX path; internally 2-flop synchronised to rx_sync.
- lane_err_pulse  in  pNUM_LANE  single-cycle axi_clk error pulses, one per lane.
- rxen_ctl  out  1  RX enable.
- txen_ctl  out  1  TX enable; 1 in every FSM state except OFF.
- lane_en  out  pNUM_LANE  per-lane enable mask.
- loopback_en  out  1  internal TX-to-RX loopback select.
- link_up  out  1  1 only in state LINKED.
- irq  out  1  level interrupt = timeout_sticky & irq_en.

Behaviour:
- Reset values:
  - rxen_ctl, txen_ctl, loopback_en, link_up, irq, axi_rvalid = 0; axi_rdata = 0.
  - lane_en = all ones.
  - TIMEOUT register = 1000 (truncated to pTIMEOUT_W).
  - FSM = OFF; timeout counter = 0; ERR_CNT = 0; synchroniser flops = 0.
- Write channel:
  - axi_awready = axi_wready = awvalid_in & wvalid_in, combinational; *_in = *valid & cc_is_enable.
  - The write commits on the same axi_clk edge.
  - Each byte lane updates only if its wstrb bit is set.
  - Writes to unmapped or read-only offsets are accepted and ignored.
- Read channel:
  - axi_arready = !axi_rvalid.
  - On arvalid_in & arready: capture the addressed data into axi_rdata and set axi_rvalid on the next edge (1-cycle latency).
  - axi_rvalid and axi_rdata are held until axi_rready = 1, then rvalid clears. At most one read is outstanding.
  - Unmapped offsets read 0.
- Register map (DW offsets):
  - 0x000 CTRL, RW: bit0 rxen, bit1 txen_req, bit2 loopback, bit3 irq_en.
  - 0x001 LANE_EN, RW: [pNUM_LANE-1:0].
  - 0x002 TIMEOUT, RW: [pTIMEOUT_W-1:0]. Value 0 disables the timeout.
  - 0x003 STATUS: [1:0] FSM state (OFF=0, WAIT=1, LINKED=2, TMO=3), RO; bit2 link_up, RO; bit3 timeout_sticky, W1C; bit4 rx_sync, RO.
  - 0x004 ERR_CNT, RO: [15:0]. Any write with wstrb != 0 clears it.
- Link FSM; the timeout counter counts only in WAIT and resets to 0 on every entry to WAIT:
  - OFF: if txen_req → WAIT; otherwise, if rxen & rx_sync → LINKED (remote side is early).
  - WAIT: if rx_sync → LINKED; otherwise, if TIMEOUT != 0 and counter == TIMEOUT−1 → TMO and set timeout_sticky.
  - TMO: if rx_sync → LINKED (late link). timeout_sticky is not cleared by this transition.
  - LINKED: if rx_sync falls → WAIT.
  - Any state: a txen_req and rxen both 0 → OFF; this has priority over all other transitions.
  - From LINKED entered via the early-remote path, clearing rxen while txen_req=0 → OFF.
- Error counter:
  - Each cycle adds popcount(lane_err_pulse & lane_en) to ERR_CNT, saturating at 16'hFFFF.
  - A clear write in the same cycle wins; that cycle's increment is discarded.
- Simultaneous events: if a W1C of timeout_sticky coincides with a new timeout event, the set wins.
- Reset mid-transaction: pending rvalid is dropped, all state returns to reset values, and no partial write occurs.

Test Plan:
- Reset, then read 0x001/0x002 → rdata 0x00000FFF (pNUM_LANE=12) / 0x000003E8; rvalid asserts 1 cycle after the arvalid handshake and is held while rready=0 for 5 cycles.
- Write CTRL=0x2, TIMEOUT=8, rx_received_data=0 → txen_ctl=1 next cycle; state TMO and STATUS bit3=1 after 8 WAIT cycles. Then set irq_en (CTRL=0xA) → irq=1. W1C STATUS bit3 → irq=0.
- CTRL=0x2, then rx_received_data=1 after 3 cycles → LINKED within 3 cycles (2-flop synchroniser + FSM); link_up=1, STATUS reads 0x16. Drop rx_received_data → WAIT, link_up=0.
- CTRL=0x1 (rxen only) with rx_received_data=1 → OFF→LINKED, txen_ctl=1. Write CTRL=0 → OFF, txen_ctl=0.
- LANE_EN=0x00F and lane_err_pulse=0xFFF for 10 cycles → ERR_CNT=40. Force near saturation → holds 0xFFFF. A write to 0x004 coinciding with a pulse → reads 0.
- cc_is_enable=0 with CTRL write → awready=wready=0 and the register is unchanged. Write CTRL with wstrb=4'b0010 → CTRL unchanged (bits live in byte 0).
